trace_buffer: RTL and testbench
===============================

Name: trace_buffer

Overview:
- Circular trace store directly downstream of dataPacker.
- Captures each packed N-wide vector (the packer's vector_out/valid_out) while tracing is high.
- When tracing is low, dumps stored vectors oldest-first to the host/readout interface over a valid/ready handshake.
- Holds the last TB_SIZE packed vectors, so the newest trace history survives wrap-around.

Parameters:
- N, 8, vector lanes; must match the packer's N.
- DATA_WIDTH, 32, bits per lane.
- TB_SIZE, 8, entries; power of two, >=2.
- AW, $clog2(TB_SIZE), pointer width (localparam, not overridable).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- tracing  input  1  1 = capture mode, 0 = dump/idle mode.
- valid_in  input  1  packed vector present (from packer valid_out).
- vector_in  input  [DATA_WIDTH-1:0] x N  packed vector (from packer vector_out).
- clear  input  1  synchronous buffer clear (pointers/count only).
- start_dump  input  1  one-cycle request to begin a dump.
- ready_in  input  1  consumer accepts vector_out this cycle.
- vector_out  output  [DATA_WIDTH-1:0] x N  registered dump data.
- valid_out  output  1  vector_out valid.
- dump_done  output  1  one-cycle pulse after the last entry is accepted.
- count  output  AW+1  number of stored entries, saturates at TB_SIZE.
- wrapped  output  1  at least one entry has been overwritten since the last clear.

Behaviour:
- Reset (async):
  - state=IDLE; wptr, rptr, remaining, count = 0; wrapped=0.
  - valid_out=0, dump_done=0, vector_out all zero.
  - Memory contents are not reset.
- FSM states: IDLE, CAPTURE, DUMP.
  - IDLE→CAPTURE when tracing=1.
  - CAPTURE→IDLE when tracing=0.
  - IDLE→DUMP on start_dump=1 with tracing=0 and count>0.
  - DUMP→IDLE after the final handshake.
  - DUMP→CAPTURE if tracing=1 (abort).
- Capture:
  - In CAPTURE (and also on the IDLE cycle where tracing first rises), valid_in=1 at edge k writes mem[wptr]; wptr wraps naturally.
  - count increments, saturating at TB_SIZE.
  - A write while count==TB_SIZE sets wrapped=1.
  - No backpressure toward the packer; every valid_in is accepted.
- Dump start:
  - rptr = (count<TB_SIZE) ? 0 : wptr; remaining = count.
  - On the same edge, vector_out<=mem[start], valid_out<=1, so data is visible one cycle after start_dump.
- Handshake:
  - Transfer occurs when valid_out&&ready_in at an edge.
  - vector_out and valid_out are held stable while ready_in=0.
  - On transfer with remaining>1: load the next entry (rptr+1, wraps) and decrement remaining; valid_out stays 1, giving back-to-back throughput of one entry per cycle.
  - On transfer with remaining==1: valid_out<=0, dump_done<=1 for exactly one cycle, go to IDLE.
- Dump does not consume data: wptr, count and wrapped are unchanged, and a second start_dump replays the same contents.
- Ignored cases:
  - start_dump while tracing=1, or while already in DUMP, is ignored.
  - start_dump with count==0: go straight to dump_done=1 pulse next cycle, no valid_out.
- Abort:
  - tracing rising during DUMP → valid_out<=0 next edge, no dump_done, state CAPTURE.
  - A valid_in on that same edge is written.
- clear:
  - Zeroes wptr, count and wrapped; in DUMP it also aborts (valid_out<=0, no dump_done).
  - Simultaneous clear and valid_in: clear wins, write dropped.
  - clear has priority over start_dump.
- Reset mid-dump or mid-capture: all state returns to reset values immediately (asynchronous).

Decomposition:
- Package trace_pkg:
  - typedef vec_t (array [N-1:0] of logic [DATA_WIDTH-1:0]).
  - enum tb_state_e {IDLE, CAPTURE, DUMP}.
- One sub-module, tb_mem:
  - Simple dual-port array, one write port, one asynchronous read port, TB_SIZE x N x DATA_WIDTH.
  - Kept separate so it can be swapped for a vendor RAM wrapper later.
- FSM, pointers and output register stay in trace_buffer.

Test Plan:
- Capture 3 vectors (lane0 = 1, 2, 3) with tracing=1, then tracing=0 and start_dump with ready_in=1 → count=3, wrapped=0; vector_out lane0 = 1, 2, 3 on consecutive cycles; dump_done on the 4th cycle after start_dump.
- Capture 11 vectors (lane0 = 1..11), TB_SIZE=8 → count=8, wrapped=1; dump yields lane0 = 4..11 in order.
- Dump with ready_in toggling 1,0,0,1,... → each vector held unchanged while ready_in=0; no skipped or duplicated entries; exactly one dump_done.
- start_dump on empty buffer → dump_done pulse one cycle later, valid_out never 1; start_dump with tracing=1 → no response.
- tracing raised after the 2nd of 5 dump transfers, valid_in=1 (lane0=99) on that edge → valid_out=0, no dump_done, count=6; a later dump shows 99 last.
- rst asserted mid-dump, asynchronously between edges → valid_out, count, wrapped drop to 0 without waiting for clk; clear with simultaneous valid_in → count=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the trace buffer: packed vector type and FSM state encoding.
package trace_pkg;

   localparam int N          = 8;
   localparam int DATA_WIDTH = 32;

   typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DUMP    = 2'd2
   } tb_state_e;

endpackage

// File: rtl/tb_mem.sv
// Trace storage: one write port, one asynchronous read port.
// Kept separate so a vendor RAM wrapper can replace it.
module tb_mem #(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TB_SIZE    = 8,
   localparam int AW        = $clog2(TB_SIZE)
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [AW-1:0]                waddr,
   input  logic [N-1:0][DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]                raddr,
   output logic [N-1:0][DATA_WIDTH-1:0] rdata
);

   logic [N-1:0][DATA_WIDTH-1:0] mem [TB_SIZE];

   // Write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Circular trace store behind the packer. Captures packed vectors while
// tracing is high and replays the newest TB_SIZE of them, oldest first,
// over a valid/ready interface when tracing is low.
module trace_buffer
   import trace_pkg::*;
#(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TB_SIZE    = 8,
   localparam int AW        = $clog2(TB_SIZE)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         tracing,
   input  logic                         valid_in,
   input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
   input  logic                         clear,
   input  logic                         start_dump,
   input  logic                         ready_in,
   output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
   output logic                         valid_out,
   output logic                         dump_done,
   output logic [AW:0]                  count,
   output logic                         wrapped
);

   localparam logic [AW:0]   FULL    = (AW+1)'(TB_SIZE);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   tb_state_e                    state;
   logic [AW-1:0]                wptr;
   logic [AW-1:0]                rptr;
   logic [AW:0]                  remaining;
   logic                         wr_en;
   logic [AW-1:0]                start_ptr;
   logic [AW-1:0]                rd_addr;
   logic [N-1:0][DATA_WIDTH-1:0] rd_data;

   // Writes happen in CAPTURE, on the cycle tracing rises, and on a dump
   // abort; clear always drops a coincident write.
   assign wr_en     = valid_in && !clear && ((state == CAPTURE) || tracing);
   // Oldest entry: slot 0 until the buffer has filled, then the write pointer.
   assign start_ptr = (count < FULL) ? '0 : wptr;
   // In IDLE the read port serves the dump start, in DUMP the next entry.
   assign rd_addr   = (state == DUMP) ? (rptr + PTR_ONE) : start_ptr;

   tb_mem #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH),
      .TB_SIZE    (TB_SIZE)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wptr),
      .wdata (vector_in),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // Control FSM, pointers, fill tracking and the registered dump output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wptr       <= '0;
         rptr       <= '0;
         remaining  <= '0;
         count      <= '0;
         wrapped    <= 1'b0;
         valid_out  <= 1'b0;
         dump_done  <= 1'b0;
         vector_out <= '0;
      end else begin
         dump_done <= 1'b0;

         if (wr_en) begin
            wptr <= wptr + PTR_ONE;
            if (count == FULL) wrapped <= 1'b1;
            else               count   <= count + CNT_ONE;
         end

         if (clear) begin
            wptr    <= '0;
            count   <= '0;
            wrapped <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (tracing) begin
                  state <= CAPTURE;
               end else if (start_dump && !clear) begin
                  if (count != '0) begin
                     rptr       <= start_ptr;
                     remaining  <= count;
                     vector_out <= rd_data;
                     valid_out  <= 1'b1;
                     state      <= DUMP;
                  end else begin
                     dump_done <= 1'b1;
                  end
               end
            end
            CAPTURE: begin
               if (!tracing) state <= IDLE;
            end
            DUMP: begin
               if (tracing || clear) begin
                  valid_out <= 1'b0;
                  state     <= tracing ? CAPTURE : IDLE;
               end else if (valid_out && ready_in) begin
                  if (remaining > CNT_ONE) begin
                     rptr       <= rptr + PTR_ONE;
                     remaining  <= remaining - CNT_ONE;
                     vector_out <= rd_data;
                  end else begin
                     valid_out <= 1'b0;
                     dump_done <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer with a reference model of the stored
// history and a scoreboard queue of expected dump vectors.
module tb_trace_buffer;
   import trace_pkg::*;

   localparam int TBS = 8;
   localparam int AW  = $clog2(TBS);

   logic        clk = 1'b0;
   logic        rst;
   logic        tracing, valid_in, clear, start_dump, ready_in;
   vec_t        vector_in, vector_out;
   logic        valid_out, dump_done, wrapped;
   logic [AW:0] count;

   int total = 0;
   int bad   = 0;

   vec_t model_q[$];
   bit   model_wr = 1'b0;
   vec_t exp_q[$];

   trace_buffer #(.N(N), .DATA_WIDTH(DATA_WIDTH), .TB_SIZE(TBS)) dut (
      .clk        (clk),
      .rst        (rst),
      .tracing    (tracing),
      .valid_in   (valid_in),
      .vector_in  (vector_in),
      .clear      (clear),
      .start_dump (start_dump),
      .ready_in   (ready_in),
      .vector_out (vector_out),
      .valid_out  (valid_out),
      .dump_done  (dump_done),
      .count      (count),
      .wrapped    (wrapped)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input int v);
      vec_t r;
      for (int j = 0; j < N; j++) r[j] = 32'(v) | (32'(j) << 16);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_i(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_v(input string tag, input vec_t obs, input vec_t expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_push(input int v);
      if (model_q.size() == TBS) begin
         model_wr = 1'b1;
         void'(model_q.pop_front());
      end
      model_q.push_back(mk(v));
   endtask

   task automatic model_clear();
      model_q.delete();
      model_wr = 1'b0;
   endtask

   task automatic capture(input int v);
      tracing   = 1'b1;
      valid_in  = 1'b1;
      vector_in = mk(v);
      step();
      valid_in  = 1'b0;
      model_push(v);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      model_clear();
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0,1,0,0,...
   task automatic run_dump(input int mode, output int done_at);
      int   got, dones, exp_n;
      bit   xfer, prev_hold;
      vec_t prev_vec;
      exp_q     = model_q;
      exp_n     = exp_q.size();
      got       = 0;
      dones     = 0;
      done_at   = -1;
      prev_hold = 1'b0;
      prev_vec  = '0;
      start_dump = 1'b1;
      ready_in   = 1'b1;
      step();
      start_dump = 1'b0;
      for (int cyc = 0; cyc < 200 && dones == 0; cyc++) begin
         if (valid_out) begin
            if (exp_q.size() > 0) check_v("dump_data", vector_out, exp_q[0]);
            else                  check_i("dump_extra", 1, 0);
            if (prev_hold) check_v("dump_hold", vector_out, prev_vec);
         end
         ready_in  = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         xfer      = valid_out && ready_in;
         prev_hold = valid_out && !ready_in;
         prev_vec  = vector_out;
         step();
         if (xfer) begin
            got++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (dump_done) begin
            dones++;
            done_at = cyc;
         end
      end
      ready_in = 1'b0;
      check_i("dump_transfers", got, exp_n);
      check_i("dump_done_seen", dones, 1);
      check_i("dump_valid_after", int'(valid_out), 0);
      step();
      check_i("dump_done_single", int'(dump_done), 0);
      check_i("dump_count_kept", int'(count), model_q.size());
      check_i("dump_wrapped_kept", int'(wrapped), int'(model_wr));
   endtask

   initial begin
      int done_at;
      rst = 1'b1;
      tracing = 1'b0; valid_in = 1'b0; clear = 1'b0;
      start_dump = 1'b0; ready_in = 1'b0; vector_in = '0;
      step();
      step();
      check_i("rst_count", int'(count), 0);
      check_i("rst_valid", int'(valid_out), 0);
      check_i("rst_done", int'(dump_done), 0);
      check_i("rst_wrapped", int'(wrapped), 0);
      check_v("rst_vector", vector_out, '0);
      rst = 1'b0;
      step();

      // Three captures, then a full-rate dump
      for (int v = 1; v <= 3; v++) capture(v);
      tracing = 1'b0;
      step();
      check_i("t1_count", int'(count), 3);
      check_i("t1_wrapped", int'(wrapped), 0);
      run_dump(0, done_at);
      check_i("t1_done_latency", done_at, 2);

      // Wrap-around: newest eight of eleven survive
      do_clear();
      check_i("t2_clear_count", int'(count), 0);
      for (int v = 1; v <= 11; v++) capture(v);
      tracing = 1'b0;
      step();
      check_i("t2_count", int'(count), TBS);
      check_i("t2_wrapped", int'(wrapped), 1);
      check_i("t2_model_first", int'(model_q[0][0]), 4);
      run_dump(0, done_at);

      // Replay with backpressure
      run_dump(1, done_at);

      // Empty dump and dump request while tracing
      do_clear();
      start_dump = 1'b1;
      step();
      start_dump = 1'b0;
      check_i("t4_empty_done", int'(dump_done), 1);
      check_i("t4_empty_valid", int'(valid_out), 0);
      step();
      check_i("t4_empty_done_off", int'(dump_done), 0);
      check_i("t4_empty_valid2", int'(valid_out), 0);
      capture(50);
      start_dump = 1'b1;
      step();
      start_dump = 1'b0;
      check_i("t4_trace_valid", int'(valid_out), 0);
      check_i("t4_trace_done", int'(dump_done), 0);
      step();
      check_i("t4_trace_valid2", int'(valid_out), 0);
      tracing = 1'b0;
      step();

      // Abort after the second of five transfers, write on the abort edge
      do_clear();
      for (int v = 21; v <= 25; v++) capture(v);
      tracing = 1'b0;
      step();
      start_dump = 1'b1;
      ready_in   = 1'b1;
      step();
      start_dump = 1'b0;
      check_v("t5_first", vector_out, mk(21));
      step();
      check_v("t5_second", vector_out, mk(22));
      step();
      check_v("t5_third", vector_out, mk(23));
      check_i("t5_valid_pre", int'(valid_out), 1);
      ready_in  = 1'b0;
      tracing   = 1'b1;
      valid_in  = 1'b1;
      vector_in = mk(99);
      step();
      valid_in = 1'b0;
      model_push(99);
      check_i("t5_abort_valid", int'(valid_out), 0);
      check_i("t5_abort_done", int'(dump_done), 0);
      check_i("t5_abort_count", int'(count), 6);
      step();
      check_i("t5_abort_done2", int'(dump_done), 0);
      tracing = 1'b0;
      step();
      check_v("t5_model_last", model_q[model_q.size()-1], mk(99));
      run_dump(0, done_at);

      // Asynchronous reset mid-dump
      for (int v = 30; v <= 32; v++) capture(v);
      tracing = 1'b0;
      step();
      check_i("t6_wrapped_pre", int'(wrapped), 1);
      start_dump = 1'b1;
      ready_in   = 1'b0;
      step();
      start_dump = 1'b0;
      check_i("t6_valid_pre", int'(valid_out), 1);
      #2;
      rst = 1'b1;
      #1;
      check_i("t6_rst_valid", int'(valid_out), 0);
      check_i("t6_rst_count", int'(count), 0);
      check_i("t6_rst_wrapped", int'(wrapped), 0);
      #1;
      rst = 1'b0;
      model_clear();
      step();

      // clear beats a simultaneous write
      capture(70);
      check_i("t6_cap_count", int'(count), 1);
      clear     = 1'b1;
      valid_in  = 1'b1;
      vector_in = mk(71);
      step();
      clear    = 1'b0;
      valid_in = 1'b0;
      model_clear();
      check_i("t6_clear_count", int'(count), 0);
      tracing = 1'b0;
      step();
      check_i("t6_clear_count2", int'(count), 0);
      check_i("t6_clear_wrapped", int'(wrapped), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
